// File: rtl/rns_pkg.sv
// rns_pkg: shared constants, FSM states and modular add/sub helpers for the
// {2^N+1, 2^N, 2^N-1} residue converter.
package rns_pkg;
  localparam int RNS_N = 3;
  localparam int W = 3 * RNS_N;
  localparam logic [RNS_N:0] MOD_0 = (RNS_N + 1)'(1 << RNS_N);
  localparam logic [RNS_N:0] MOD_M1 = (RNS_N + 1)'((1 << RNS_N) - 1);
  localparam logic [RNS_N+1:0] MOD_P1 = (RNS_N + 2)'((1 << RNS_N) + 1);
  localparam logic signed [W-1:0] M_HALF = W'((1 << (RNS_N - 1)) * ((1 << (2 * RNS_N)) - 1));
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, FIX, DONE} state_t;
  // Subtracting MOD_M1 whenever the sum reaches it also folds 2^N-1 to 0
  function automatic logic [RNS_N-1:0] add_mod_m1(input logic [RNS_N-1:0] a, input logic [RNS_N-1:0] b);
    logic [RNS_N:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= MOD_M1 ? RNS_N'(s - MOD_M1) : s[RNS_N-1:0];
  endfunction
  function automatic logic [RNS_N-1:0] sub_mod_m1(input logic [RNS_N-1:0] a, input logic [RNS_N-1:0] b);
    logic [RNS_N:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[RNS_N] ? RNS_N'(d + MOD_M1) : d[RNS_N-1:0];
  endfunction
  function automatic logic [RNS_N:0] add_mod_p1(input logic [RNS_N:0] a, input logic [RNS_N-1:0] b);
    logic [RNS_N+1:0] s;
    s = {1'b0, a} + {2'b0, b};
    return s >= MOD_P1 ? (RNS_N + 1)'(s - MOD_P1) : s[RNS_N:0];
  endfunction
  function automatic logic [RNS_N:0] sub_mod_p1(input logic [RNS_N:0] a, input logic [RNS_N-1:0] b);
    logic [RNS_N+1:0] d;
    d = {1'b0, a} - {2'b0, b};
    return d[RNS_N+1] ? (RNS_N + 1)'(d + MOD_P1) : d[RNS_N:0];
  endfunction
endpackage

// File: rtl/rns_forward_converter_if.sv
// rns_forward_converter_if: operand/result handshake bundle of the forward converter.
interface rns_forward_converter_if #(
  parameter int N = 3
);
  logic in_valid;
  logic in_ready;
  logic signed [3*N-1:0] X;
  logic out_valid;
  logic out_ready;
  logic [N:0] R1;
  logic [N-1:0] R0;
  logic [N-1:0] R_1;
  logic ovf;
  modport master (output in_valid, X, out_ready, input in_ready, out_valid, R1, R0, R_1, ovf);
  modport slave (input in_valid, X, out_ready, output in_ready, out_valid, R1, R0, R_1, ovf);
endinterface

// File: rtl/rns_mod_addsub.sv
// rns_mod_addsub: combinational add/sub modulo 2^N+1 (PLUS=1) or 2^N-1 (PLUS=0).
module rns_mod_addsub
  import rns_pkg::*;
#(
  parameter int N = RNS_N,
  parameter bit PLUS = 1'b1
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N:0]   y
);
  assign y = PLUS ? (sub ? sub_mod_p1(a, b) : add_mod_p1(a, b))
                  : {1'b0, sub ? sub_mod_m1(a[N-1:0], b) : add_mod_m1(a[N-1:0], b)};
endmodule

// File: rtl/rns_forward_converter.sv
// rns_forward_converter: reduces a signed 3N-bit operand chunk by chunk into
// residues mod 2^N+1, 2^N and 2^N-1, flagging values outside the signed range.
module rns_forward_converter
  import rns_pkg::*;
#(
  parameter int N = RNS_N
) (
  input logic clk,
  input logic rst_n,
  rns_forward_converter_if.slave io
);
  state_t state_q, state_d;
  logic [3*N-1:0] x_q, x_d;
  logic [N:0] acc_m_q, acc_m_d, acc_p_q, acc_p_d, r1_q, r1_d, m_sum, p_sum;
  logic [N-1:0] r0_q, r0_d, rm1_q, rm1_d, chunk;
  logic ovf_q, ovf_d;
  // FIX feeds the sign bit through the same adders: 2^3N is +1 mod 2^N-1, -1 mod 2^N+1
  assign chunk = state_q == ACC0 ? x_q[N-1:0]
               : state_q == ACC1 ? x_q[2*N-1:N]
               : state_q == ACC2 ? x_q[3*N-1:2*N] : N'(x_q[3*N-1]);
  rns_mod_addsub #(.N(N), .PLUS(1'b0)) u_m (.a(acc_m_q), .b(chunk), .sub(state_q == FIX), .y(m_sum));
  rns_mod_addsub #(.N(N), .PLUS(1'b1)) u_p (.a(acc_p_q), .b(chunk), .sub(state_q == ACC1), .y(p_sum));
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    acc_m_d = acc_m_q;
    acc_p_d = acc_p_q;
    r1_d = r1_q;
    r0_d = r0_q;
    rm1_d = rm1_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        state_d = ACC0;
        x_d = io.X;
        r0_d = io.X[N-1:0];
        ovf_d = (io.X < -M_HALF) || (io.X >= M_HALF);
        acc_m_d = '0;
        acc_p_d = '0;
      end
      ACC0, ACC1, ACC2: begin
        acc_m_d = m_sum;
        acc_p_d = p_sum;
        state_d = state_q == ACC0 ? ACC1 : state_q == ACC1 ? ACC2 : FIX;
      end
      FIX: begin
        rm1_d = m_sum[N-1:0];
        r1_d = p_sum;
        state_d = DONE;
      end
      DONE: state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      acc_m_q <= '0;
      acc_p_q <= '0;
      r1_q <= '0;
      r0_q <= '0;
      rm1_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      acc_m_q <= acc_m_d;
      acc_p_q <= acc_p_d;
      r1_q <= r1_d;
      r0_q <= r0_d;
      rm1_q <= rm1_d;
      ovf_q <= ovf_d;
    end
  end
  assign io.in_ready = state_q == IDLE;
  assign io.out_valid = state_q == DONE;
  assign io.R1 = r1_q;
  assign io.R0 = r0_q;
  assign io.R_1 = rm1_q;
  assign io.ovf = ovf_q;
endmodule

// File: tb/tb_rns_forward_converter.sv
// tb_rns_forward_converter: table vectors, latency/backpressure/reset sequences
// and a full signed sweep, all checked through an expected-result queue.
module tb_rns_forward_converter;
  localparam int MH = 252;
  typedef struct {
    logic [8:0] x;
    logic [3:0] r1;
    logic [2:0] r0;
    logic [2:0] rm1;
    logic ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  int n_sent = 0;
  int n_out = 0;
  vec_t sb[$];
  vec_t tbl[9];
  vec_t mon_e;
  rns_forward_converter_if #(.N(3)) bus ();
  rns_forward_converter #(.N(3)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  function automatic vec_t model(input int v);
    vec_t e;
    e.x = 9'(v);
    e.r1 = 4'(((v % 9) + 9) % 9);
    e.r0 = 3'(((v % 8) + 8) % 8);
    e.rm1 = 3'(((v % 7) + 7) % 7);
    e.ovf = (v < -MH) || (v > MH - 1);
    return e;
  endfunction
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t e, input bit keep);
    int n = 0;
    bit ok = 0;
    bus.X = e.x;
    bus.in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (ok) begin
        sb.push_back(e);
        n_sent++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("accept timeout", 0, 1);
    if (!keep) bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain timeout", 0, 1);
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("unexpected output", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk($sformatf("R1 x=%0d", $signed(mon_e.x)), int'(bus.R1), int'(mon_e.r1));
        chk($sformatf("R0 x=%0d", $signed(mon_e.x)), int'(bus.R0), int'(mon_e.r0));
        chk($sformatf("R_1 x=%0d", $signed(mon_e.x)), int'(bus.R_1), int'(mon_e.rm1));
        chk($sformatf("ovf x=%0d", $signed(mon_e.x)), int'(bus.ovf), int'(mon_e.ovf));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    int n;
    tbl[0] = '{9'h104, 4'd0, 3'd4, 3'd0, 1'b0};
    tbl[1] = '{9'h0FB, 4'd8, 3'd3, 3'd6, 1'b0};
    tbl[2] = '{9'h1FF, 4'd8, 3'd7, 3'd6, 1'b0};
    tbl[3] = '{9'h064, 4'd1, 3'd4, 3'd2, 1'b0};
    tbl[4] = '{9'h000, 4'd0, 3'd0, 3'd0, 1'b0};
    tbl[5] = '{9'h0FF, 4'd3, 3'd7, 3'd3, 1'b1};
    tbl[6] = '{9'h100, 4'd5, 3'd0, 3'd3, 1'b1};
    tbl[7] = '{9'h0FC, 4'd0, 3'd4, 3'd0, 1'b1};
    tbl[8] = '{9'h103, 4'd8, 3'd3, 3'd6, 1'b1};
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.X = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset R1", int'(bus.R1), 0);
    chk("reset R0", int'(bus.R0), 0);
    chk("reset R_1", int'(bus.R_1), 0);
    chk("reset ovf", int'(bus.ovf), 0);
    rst_n = 1'b1;
    // out_valid should appear in the fifth cycle after the accept cycle
    send(tbl[0], 1'b0);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) lat = k;
    end
    chk("latency edges after accept", lat, 4);
    drain();
    for (int i = 1; i < 9; i++) begin
      send(tbl[i], 1'b0);
      drain();
    end
    bus.out_ready = 1'b0;
    send(tbl[3], 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      chk("bp out_valid", int'(bus.out_valid), 1);
      chk("bp R1", int'(bus.R1), 1);
      chk("bp R0", int'(bus.R0), 4);
      chk("bp R_1", int'(bus.R_1), 2);
      chk("bp in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    chk("bp in_ready in transfer cycle", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("bp in_ready after transfer", int'(bus.in_ready), 1);
    chk("bp out_valid after transfer", int'(bus.out_valid), 0);
    send(model(123), 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    n_sent -= sb.size();
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst in_ready", int'(bus.in_ready), 1);
    chk("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst R1", int'(bus.R1), 0);
    chk("midrst R0", int'(bus.R0), 0);
    chk("midrst R_1", int'(bus.R_1), 0);
    chk("midrst ovf", int'(bus.ovf), 0);
    rst_n = 1'b1;
    send(tbl[4], 1'b0);
    drain();
    // in_valid stays high across the whole sweep
    for (int v = -256; v < 256; v++) send(model(v), 1'b1);
    bus.in_valid = 1'b0;
    drain();
    chk("queue empty", sb.size(), 0);
    chk("output count", n_out, n_sent);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
